piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, number of data bits per word (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: load_valid  input  1  parallel word offered.
REQ-005 SHALL have port: load_ready  output  1  block can accept a word.
REQ-006 SHALL have port: load_data  input  WIDTH  parallel word, sampled on accepted load.
REQ-007 SHALL have port: shift_en  input  1  level enable; advance one bit per cycle while high.
REQ-008 SHALL have port: sout  output  1  serial data bit, MSB first.
REQ-009 SHALL have port: sout_valid  output  1  sout carries a live bit.
REQ-010 SHALL have port: done  output  1  one-cycle pulse after last bit.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
- IDLE->SHIFT on load_valid&&load_ready; SHIFT->DONE after last bit shifted; DONE->IDLE unconditionally next cycle.
REQ-012 SHALL drive load_ready=1 only in IDLE; load_valid outside IDLE ignored, no word lost or corrupted.
REQ-013 SHALL capture load_data into shift register on the accepting edge; load_data changes afterwards have no effect.
REQ-014 SHALL present load_data[WIDTH-1] on sout with sout_valid=1 in the first SHIFT cycle (latency 1 clock from accept).
REQ-015 SHALL, in SHIFT, advance to next bit only on edges where shift_en=1; shift_en=0 holds sout, bit count and state unchanged.
REQ-016 SHALL leave SHIFT on the edge where shift_en=1 and the final bit is on sout.
REQ-017 SHALL drive sout=0, sout_valid=0 in IDLE and DONE.
REQ-018 SHALL assert done=1 only in DONE, exactly one cycle per word.
REQ-019 SHALL hold bit counter width ceil(log2(WIDTH+2)); counter never wraps within a word, cleared on each accept.
REQ-020 SHALL accept a new word earliest in the IDLE cycle following DONE (load_valid held high -> back-to-back words with one DONE and one IDLE gap cycle).

Reset
REQ-021 SHALL, on rst_n low, immediately force state IDLE, shift register 0, counter 0, sout=0, sout_valid=0, done=0, load_ready=0.
REQ-022 SHALL assert load_ready=1 from the first rising clk edge after rst_n deasserts.
REQ-023 SHALL abandon any word in progress on reset mid-SHIFT; no done pulse for that word.

Configuration
REQ-024 SHALL support macro PISO_TX_PARITY_EN.
- Defined: one even-parity bit (XOR of captured word) follows the LSB as an extra SHIFT bit with sout_valid=1; word length WIDTH+1 bits.
- Undefined: no parity bit, word length WIDTH; no parity logic synthesized.

Structure
REQ-025 SHALL place FSM state typedef (IDLE, SHIFT, DONE) and default WIDTH constant in shared package piso_tx_pkg.
REQ-026 SHALL implement bit counting in one sub-module piso_bitcnt (clear, enable, terminal-count output, async active-low reset).

Verification (WIDTH=8)
REQ-027 SHALL cover: load 0xA5, shift_en=1 continuously -> sout 1,0,1,0,0,1,0,1 on cycles 1..8 after accept, done=1 cycle 9, load_ready=1 cycle 10.
REQ-028 SHALL cover: load 0x3C, shift_en=0 for 3 cycles after bit 2 -> sout held at bit 2 value (1) for 4 cycles total, remaining bits unchanged, done delayed 3 cycles.
REQ-029 SHALL cover: rst_n low at SHIFT bit 4 of 0xFF -> sout=0, sout_valid=0 immediately, no done, load_ready=1 after release.
REQ-030 SHALL cover: load_valid pulsed with 0x00 during SHIFT of 0x81 -> ignored; sout stream stays 1,0,0,0,0,0,0,1.
REQ-031 SHALL cover: load_valid held high with 0x5A then 0xC3 -> two complete streams, one DONE plus one IDLE cycle between them.
REQ-032 SHALL cover, with PISO_TX_PARITY_EN: 0xA5 -> 9th bit 0; 0x07 -> 9th bit 1; done on cycle 10.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared types and defaults for the piso_tx serializer.
package piso_tx_pkg;

  localparam int unsigned PISO_TX_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_e;

endpackage

// File: rtl/piso_bitcnt.sv
// Bit counter for piso_tx: clears on accept, advances per shifted bit,
// saturates at LAST so it never wraps within a word.
module piso_bitcnt #(
  parameter int unsigned CW   = 4,
  parameter int unsigned LAST = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q;

  assign tc_o = (cnt_q == CW'(LAST));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, with one-cycle done pulse.
// Optional even-parity trailer bit when PISO_TX_PARITY_EN is defined.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH = PISO_TX_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

`ifdef PISO_TX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 2);

  piso_state_e      state_q;
  logic [NBITS-2:0] rest_q;
  logic [NBITS-2:0] rest_d;
  logic             sout_q;
  logic             sout_valid_q;
  logic             done_q;
  logic             load_ready_q;
  logic             accept;
  logic             advance;
  logic             last_bit;

  // rest_q holds the bits still queued behind the one currently on sout
`ifdef PISO_TX_PARITY_EN
  assign rest_d = {load_data[WIDTH-2:0], ^load_data};
`else
  assign rest_d = load_data[WIDTH-2:0];
`endif

  assign accept  = (state_q == IDLE) && load_valid && load_ready_q;
  assign advance = (state_q == SHIFT) && shift_en;

  piso_bitcnt #(
    .CW   (CW),
    .LAST (NBITS - 1)
  ) u_bitcnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (accept),
    .en_i   (advance),
    .tc_o   (last_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rest_q       <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q       <= 1'b0;
          sout_q       <= 1'b0;
          sout_valid_q <= 1'b0;
          load_ready_q <= 1'b1;
          if (accept) begin
            state_q      <= SHIFT;
            rest_q       <= rest_d;
            sout_q       <= load_data[WIDTH-1];
            sout_valid_q <= 1'b1;
            load_ready_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (advance) begin
            if (last_bit) begin
              state_q      <= DONE;
              sout_q       <= 1'b0;
              sout_valid_q <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              sout_q <= rest_q[NBITS-2];
              rest_q <= rest_q << 1;
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          done_q       <= 1'b0;
          load_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          sout_q       <= 1'b0;
          sout_valid_q <= 1'b0;
          done_q       <= 1'b0;
          load_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = load_ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx (WIDTH=8); expected streams are derived
// from the word value and the applied shift_en pattern.
module tb_piso_tx;

  localparam int unsigned W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif
  localparam int unsigned NEVER = 999;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data  = '0;
  logic         shift_en   = 1'b0;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k-th transmitted bit of word w: MSB first, then optional even parity
  function automatic logic exp_bit(input logic [W-1:0] w, input int unsigned k);
    if (k < W) return w[W-1-k];
    return ^w;
  endfunction

  task automatic chk_quiet(input string tag, input logic exp_ready, input logic exp_done);
    chk({tag, "_sout"},  sout,       1'b0);
    chk({tag, "_valid"}, sout_valid, 1'b0);
    chk({tag, "_done"},  done,       exp_done);
    chk({tag, "_ready"}, load_ready, exp_ready);
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic send_word(input logic [W-1:0] w, input bit rand_stall,
                           input int unsigned stall_at, input int unsigned stall_len,
                           input bit noise, input int unsigned pulse_at,
                           input bit hold, input logic [W-1:0] nxt);
    int unsigned k = 0;
    int unsigned stalled = 0;
    int unsigned guard = 0;
    while (load_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", load_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    if (hold) load_data = nxt;
    else begin
      load_valid = 1'b0;
      load_data  = W'($urandom);
    end
    while (k < NB && guard < 200) begin
      chk("sout",       sout,       exp_bit(w, k));
      chk("sout_valid", sout_valid, 1'b1);
      chk("done_busy",  done,       1'b0);
      chk("ready_busy", load_ready, 1'b0);
      if (k == stall_at && stalled < stall_len) begin
        shift_en = 1'b0;
        stalled++;
      end else if (rand_stall) shift_en = ($urandom_range(0, 3) != 0);
      else shift_en = 1'b1;
      if (!hold) begin
        if (k == pulse_at) begin
          load_valid = 1'b1;
          load_data  = '0;
        end else if (noise) begin
          load_valid = 1'($urandom);
          load_data  = W'($urandom);
        end else load_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
      if (shift_en) k++;
    end
    chk("stream_len", k, NB);
    chk_quiet("done_cyc", 1'b0, 1'b1);
    if (!hold) load_valid = 1'b0;
    shift_en = 1'($urandom);
    @(negedge clk);
    chk_quiet("idle_cyc", 1'b1, 1'b0);
  endtask

  initial begin
    #2;
    chk_quiet("reset", 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", load_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_rst", load_ready, 1'b1);

    // Continuous shifting, then a stall of 3 cycles on bit index 2
    send_word(8'hA5, 1'b0, NEVER, 0, 1'b0, NEVER, 1'b0, '0);
    send_word(8'h3C, 1'b0, 2, 3, 1'b0, NEVER, 1'b0, '0);
    // Stray load_valid with 0x00 mid-word must be ignored
    send_word(8'h81, 1'b0, NEVER, 0, 1'b0, 3, 1'b0, '0);
    send_word(8'h07, 1'b0, NEVER, 0, 1'b0, NEVER, 1'b0, '0);
    // load_valid held high across two words
    send_word(8'h5A, 1'b0, NEVER, 0, 1'b0, NEVER, 1'b1, 8'hC3);
    send_word(8'hC3, 1'b0, NEVER, 0, 1'b0, NEVER, 1'b0, '0);

    // Reset in the middle of 0xFF, while bit index 4 is on sout
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(negedge clk);
    load_valid = 1'b0;
    shift_en   = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_bit4", sout, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_quiet("mid_rst", 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_ready", load_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", load_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_quiet("no_done_after_abort", 1'b1, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      send_word(W'($urandom), 1'b1, NEVER, 0, 1'b1, NEVER, 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
